dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_mask.sv | 36 +++
 rtl/dmem_responder.sv | 132 +++++++++++++
 tb/tb_dmem_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned BLOCK_BITS      = 256;
    localparam int unsigned WORD_BITS       = 32;
    localparam int unsigned WORDS_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        BLK_IDLE = 2'd0,
        BLK_BUSY = 2'd1,
        BLK_DONE = 2'd2
    } blk_state_e;

endpackage

// File: rtl/dmem_lane_mask.sv
// Byte-lane enable and data alignment for sub-word writes.
// size 1..3 writes that many low bytes of wdata starting at lane byte_off;
// lanes past 3 fall off the word. size 0 is a full 4-byte write.
module dmem_lane_mask
    import dmem_pkg::*;
(
    input  logic [1:0]           byte_off,
    input  logic [1:0]           size,
    input  logic [WORD_BITS-1:0] wdata,
    output logic [3:0]           lane_en,
    output logic [WORD_BITS-1:0] wdata_aligned
);

    logic [3:0] span;

    // Build the lane span from the size, then shift it and the data up to the byte offset.
    always_comb begin
        span          = '0;
        lane_en       = '0;
        wdata_aligned = '0;
        case (size)
            2'd1:    span = 4'b0001;
            2'd2:    span = 4'b0011;
            2'd3:    span = 4'b0111;
            default: span = 4'b1111;
        endcase
        if (size == 2'd0) begin
            lane_en       = '1;
            wdata_aligned = wdata;
        end else begin
            lane_en       = span << byte_off;
            wdata_aligned = wdata << {byte_off, 3'b000};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data memory with a zero-latency word port and a fixed-latency block port.
// Word reads/writes never stall; block requests run through an
// IDLE/BUSY/DONE FSM and complete with a one-cycle valid pulse.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BLOCKS = 64,
    parameter int unsigned BLK_LATENCY  = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            data_address_2DM,
    input  logic                   MemRead_2DM,
    input  logic                   MemWrite_2DM,
    input  logic [WORD_BITS-1:0]   data_write_2DM,
    input  logic [1:0]             data_write_size_2DM,
    output logic [WORD_BITS-1:0]   data_read_fDM,
    input  logic                   dBlkRead,
    input  logic                   dBlkWrite,
    input  logic [BLOCK_BITS-1:0]  block_write_2DM,
    output logic [BLOCK_BITS-1:0]  block_read_fDM,
    output logic                   block_read_fDM_valid,
    output logic                   block_write_fDM_valid
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BLOCKS);

    logic [WORD_BITS-1:0]  mem [DEPTH_BLOCKS][WORDS_PER_BLOCK];

    logic [IDX_W-1:0]      addr_blk;
    logic [2:0]            addr_word;
    logic [3:0]            lane_en;
    logic [WORD_BITS-1:0]  wdata_aligned;
    logic                  unused_addr_bits;

    blk_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLOCK_BITS-1:0] wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0] block_read_q, block_read_d;
    logic                  blk_commit;

    assign addr_blk         = data_address_2DM[5+IDX_W-1:5];
    assign addr_word        = data_address_2DM[4:2];
    assign unused_addr_bits = ^data_address_2DM[31:5+IDX_W];

    dmem_lane_mask u_lane_mask (
        .byte_off      (data_address_2DM[1:0]),
        .size          (data_write_size_2DM),
        .wdata         (data_write_2DM),
        .lane_en       (lane_en),
        .wdata_aligned (wdata_aligned)
    );

    // Word read port: combinational, zero when not reading.
    always_comb begin
        data_read_fDM = '0;
        if (MemRead_2DM) data_read_fDM = mem[addr_blk][addr_word];
    end

    // Block FSM next state; commit and read sampling use the *_d view so a
    // latency-1 request is serviced on its own acceptance edge.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_wr_d      = op_wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        block_read_d = block_read_q;
        case (state_q)
            BLK_IDLE: begin
                if (dBlkWrite || dBlkRead) begin
                    op_wr_d = dBlkWrite;
                    idx_d   = addr_blk;
                    if (dBlkWrite) wdata_d = block_write_2DM;
                    cnt_d   = 4'(BLK_LATENCY - 1);
                    state_d = (BLK_LATENCY == 1) ? BLK_DONE : BLK_BUSY;
                end
            end
            BLK_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = BLK_DONE;
            end
            BLK_DONE: state_d = BLK_IDLE;
            default:  state_d = BLK_IDLE;
        endcase
        if (state_d == BLK_DONE && !op_wr_d) begin
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++)
                block_read_d[w*WORD_BITS +: WORD_BITS] = mem[idx_d][w];
        end
    end

    assign blk_commit = RESET && (state_d == BLK_DONE) && op_wr_d;

    // Block FSM and latched request registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= BLK_IDLE;
            cnt_q        <= '0;
            op_wr_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            block_read_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_wr_q      <= op_wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            block_read_q <= block_read_d;
        end
    end

    // Storage (not reset). Word-write bytes are assigned last so they win
    // over a block commit landing on the same word in the same edge.
    always_ff @(posedge CLK) begin
        if (blk_commit) begin
            for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++)
                mem[idx_d][w] <= wdata_d[w*WORD_BITS +: WORD_BITS];
        end
        if (MemWrite_2DM) begin
            for (int unsigned b = 0; b < 4; b++)
                if (lane_en[b]) mem[addr_blk][addr_word][b*8 +: 8] <= wdata_aligned[b*8 +: 8];
        end
    end

    assign block_read_fDM        = block_read_q;
    assign block_read_fDM_valid  = (state_q == BLK_DONE) && !op_wr_q;
    assign block_write_fDM_valid = (state_q == BLK_DONE) &&  op_wr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (64 blocks, latency 4).
module tb_dmem_responder;
    import dmem_pkg::*;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  data_address_2DM;
    logic         MemRead_2DM;
    logic         MemWrite_2DM;
    logic [31:0]  data_write_2DM;
    logic [1:0]   data_write_size_2DM;
    logic [31:0]  data_read_fDM;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         block_read_fDM_valid;
    logic         block_write_fDM_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [255:0] pat_a, pat_b, pat_c, pat_d;

    dmem_responder #(.DEPTH_BLOCKS(64), .BLK_LATENCY(4)) dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .data_address_2DM      (data_address_2DM),
        .MemRead_2DM           (MemRead_2DM),
        .MemWrite_2DM          (MemWrite_2DM),
        .data_write_2DM        (data_write_2DM),
        .data_write_size_2DM   (data_write_size_2DM),
        .data_read_fDM         (data_read_fDM),
        .dBlkRead              (dBlkRead),
        .dBlkWrite             (dBlkWrite),
        .block_write_2DM       (block_write_2DM),
        .block_read_fDM        (block_read_fDM),
        .block_read_fDM_valid  (block_read_fDM_valid),
        .block_write_fDM_valid (block_write_fDM_valid)
    );

    always #5 CLK = ~CLK;

    task automatic word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge CLK);
        data_address_2DM    = a;
        data_write_2DM      = d;
        data_write_size_2DM = sz;
        MemWrite_2DM        = 1'b1;
        @(posedge CLK);
        #1 MemWrite_2DM = 1'b0;
    endtask

    task automatic word_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        data_address_2DM = a;
        MemRead_2DM      = 1'b1;
        #1 d = data_read_fDM;
        MemRead_2DM = 1'b0;
    endtask

    // Watches n falling edges after an acceptance edge, dropping each request once its valid is seen.
    task automatic blk_watch(input int n, output int rd_first, output int wr_first,
                             output int rd_cnt, output int wr_cnt, output logic [255:0] rdata);
        rd_first = -1; wr_first = -1; rd_cnt = 0; wr_cnt = 0; rdata = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (block_read_fDM_valid) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = i;
                rdata = block_read_fDM;
                dBlkRead = 1'b0;
            end
            if (block_write_fDM_valid) begin
                wr_cnt++;
                if (wr_first < 0) wr_first = i;
                dBlkWrite = 1'b0;
            end
        end
    endtask

    task automatic blk_start(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] d);
        @(negedge CLK);
        data_address_2DM = a;
        block_write_2DM  = d;
        dBlkRead         = rd;
        dBlkWrite        = wr;
        @(posedge CLK);
    endtask

    task automatic test_reset;
        tests_run++;
        if ({block_read_fDM_valid, block_write_fDM_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_valids: got %b expected 00", {block_read_fDM_valid, block_write_fDM_valid});
        end
        tests_run++;
        if (block_read_fDM !== '0) begin
            tests_failed++;
            $display("FAIL reset_block_read: got %h expected 0", block_read_fDM);
        end
        tests_run++;
        if (dut.state_q !== BLK_IDLE || dut.cnt_q !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_fsm: got state %0d cnt %0d expected 0 0", dut.state_q, dut.cnt_q);
        end
        tests_run++;
        if (data_read_fDM !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_word_idle: got %h expected 0", data_read_fDM);
        end
    endtask

    task automatic test_word_full;
        logic [31:0] d;
        word_write(32'h40, 32'hDEADBEEF, 2'd0);
        word_read(32'h40, d);
        tests_run++;
        if (d !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_full: got %h expected DEADBEEF", d);
        end
        word_read(32'h840, d);
        tests_run++;
        if (d !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_alias: got %h expected DEADBEEF", d);
        end
        @(negedge CLK);
        data_address_2DM = 32'h40;
        MemRead_2DM = 1'b0;
        #1;
        tests_run++;
        if (data_read_fDM !== 32'h0) begin
            tests_failed++;
            $display("FAIL word_noread: got %h expected 0", data_read_fDM);
        end
    endtask

    task automatic test_word_bytes;
        logic [31:0] d;
        word_write(32'h40, 32'h11223344, 2'd0);
        word_write(32'h42, 32'h000000AA, 2'd1);
        word_read(32'h40, d);
        tests_run++;
        if (d !== 32'h11AA3344) begin
            tests_failed++;
            $display("FAIL word_size1: got %h expected 11AA3344", d);
        end
        word_write(32'h43, 32'h00CCBBEE, 2'd3);
        word_read(32'h40, d);
        tests_run++;
        if (d !== 32'hEEAA3344) begin
            tests_failed++;
            $display("FAIL word_size3_top: got %h expected EEAA3344", d);
        end
        word_write(32'h41, 32'hFFFF5566, 2'd2);
        word_read(32'h40, d);
        tests_run++;
        if (d !== 32'hEE556644) begin
            tests_failed++;
            $display("FAIL word_size2: got %h expected EE556644", d);
        end
    endtask

    task automatic test_block_rw;
        int rf, wf, rc, wc;
        logic [255:0] rd;
        blk_start(1'b0, 1'b1, 32'h100, pat_a);
        blk_watch(12, rf, wf, rc, wc, rd);
        tests_run++;
        if (wf !== 4 || wc !== 1 || rc !== 0) begin
            tests_failed++;
            $display("FAIL blk_write_timing: got first %0d count %0d rdcount %0d expected 4 1 0", wf, wc, rc);
        end
        blk_start(1'b1, 1'b0, 32'h100, '0);
        blk_watch(12, rf, wf, rc, wc, rd);
        tests_run++;
        if (rf !== 4 || rc !== 1 || wc !== 0) begin
            tests_failed++;
            $display("FAIL blk_read_timing: got first %0d count %0d wrcount %0d expected 4 1 0", rf, rc, wc);
        end
        tests_run++;
        if (rd !== pat_a) begin
            tests_failed++;
            $display("FAIL blk_read_data: got %h expected %h", rd, pat_a);
        end
        tests_run++;
        if (block_read_fDM !== pat_a) begin
            tests_failed++;
            $display("FAIL blk_read_hold: got %h expected %h", block_read_fDM, pat_a);
        end
    endtask

    task automatic test_back_to_back;
        int rf, wf, rc, wc;
        logic [255:0] rd;
        blk_start(1'b1, 1'b1, 32'h100, pat_b);
        blk_watch(16, rf, wf, rc, wc, rd);
        tests_run++;
        if (wf !== 4 || wc !== 1) begin
            tests_failed++;
            $display("FAIL both_write_first: got first %0d count %0d expected 4 1", wf, wc);
        end
        tests_run++;
        if (rf !== 9 || rc !== 1) begin
            tests_failed++;
            $display("FAIL both_read_later: got first %0d count %0d expected 9 1", rf, rc);
        end
        tests_run++;
        if (rd !== pat_b) begin
            tests_failed++;
            $display("FAIL both_read_data: got %h expected %h", rd, pat_b);
        end
    endtask

    task automatic test_reset_busy;
        int rf, wf, rc, wc;
        logic [255:0] rd;
        blk_start(1'b0, 1'b1, 32'h100, pat_c);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        dBlkWrite = 1'b0;
        #1;
        tests_run++;
        if (dut.state_q !== BLK_IDLE || block_read_fDM_valid !== 1'b0 || block_write_fDM_valid !== 1'b0
            || block_read_fDM !== '0) begin
            tests_failed++;
            $display("FAIL rst_busy_state: got state %0d rv %b wv %b rdata_zero %b expected 0 0 0 1",
                     dut.state_q, block_read_fDM_valid, block_write_fDM_valid, block_read_fDM == '0);
        end
        @(negedge CLK);
        RESET = 1'b1;
        blk_watch(8, rf, wf, rc, wc, rd);
        tests_run++;
        if (rc !== 0 || wc !== 0) begin
            tests_failed++;
            $display("FAIL rst_busy_novalid: got rd %0d wr %0d expected 0 0", rc, wc);
        end
        blk_start(1'b1, 1'b0, 32'h100, '0);
        blk_watch(12, rf, wf, rc, wc, rd);
        tests_run++;
        if (rd !== pat_b || rc !== 1) begin
            tests_failed++;
            $display("FAIL rst_busy_old_data: got %h count %0d expected %h 1", rd, rc, pat_b);
        end
    endtask

    task automatic test_collision;
        int wf = -1;
        logic [31:0] d;
        logic [31:0] exp_w;
        blk_start(1'b0, 1'b1, 32'h100, pat_d);
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (i == 3) begin
                data_address_2DM    = 32'h108;
                data_write_2DM      = 32'h600DF00D;
                data_write_size_2DM = 2'd0;
                MemWrite_2DM        = 1'b1;
            end
            if (i == 4) MemWrite_2DM = 1'b0;
            if (block_write_fDM_valid) begin
                if (wf < 0) wf = i;
                dBlkWrite = 1'b0;
            end
        end
        tests_run++;
        if (wf !== 4) begin
            tests_failed++;
            $display("FAIL coll_write_timing: got %0d expected 4", wf);
        end
        for (int w = 0; w < 8; w++) begin
            word_read(32'h100 + 32'(w * 4), d);
            exp_w = (w == 2) ? 32'h600DF00D : 32'hD0D0_0000 + 32'(w);
            tests_run++;
            if (d !== exp_w) begin
                tests_failed++;
                $display("FAIL coll_word%0d: got %h expected %h", w, d, exp_w);
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 8; w++) begin
            pat_a[w*32 +: 32] = 32'hA0A0_0000 + 32'(w);
            pat_b[w*32 +: 32] = 32'hB0B0_0000 + 32'(w);
            pat_c[w*32 +: 32] = 32'hC0C0_0000 + 32'(w);
            pat_d[w*32 +: 32] = 32'hD0D0_0000 + 32'(w);
        end
        RESET               = 1'b0;
        data_address_2DM    = '0;
        MemRead_2DM         = 1'b0;
        MemWrite_2DM        = 1'b0;
        data_write_2DM      = '0;
        data_write_size_2DM = '0;
        dBlkRead            = 1'b0;
        dBlkWrite           = 1'b0;
        block_write_2DM     = '0;
        repeat (2) @(negedge CLK);
        test_reset();
        RESET = 1'b1;
        test_word_full();
        test_word_bytes();
        test_block_rw();
        test_back_to_back();
        test_reset_busy();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
